// File: rtl/tick_timer.sv
// Loadable-divisor tick generator with a tick counter, terminal count, one-shot mode and pause/abort.
// Define TICK_TIMER_SQUARE_EN to add the 50% duty `square` output toggled on every tick.
module tick_timer #(
   parameter int unsigned WIDTH       = 28,
   parameter int unsigned DEFAULT_DIV = 1000000,
   parameter int unsigned CNT_WIDTH   = 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 enable,
   input  logic                 mode,
   input  logic                 div_load,
   input  logic [WIDTH-1:0]     div_value,
   input  logic [CNT_WIDTH-1:0] tc_value,
   output logic                 tick,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] tick_count,
`ifdef TICK_TIMER_SQUARE_EN
   output logic                 square,
`endif
   output logic                 busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0]     DIV_ONE   = WIDTH'(1);
   localparam logic [WIDTH-1:0]     DIV_RESET = WIDTH'(DEFAULT_DIV);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   state_t               state_q, state_d;
   logic                 mode_q, mode_d;
   logic [WIDTH-1:0]     div_q, div_d;
   logic [WIDTH-1:0]     pre_q, pre_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 tick_q, tick_d;
   logic                 done_q, done_d;
`ifdef TICK_TIMER_SQUARE_EN
   logic                 square_q, square_d;
`endif

   // NOTE: every variable gets its hold/default value first so no path leaves one unassigned (no latches).
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      div_d    = div_q;
      pre_d    = pre_q;
      cnt_d    = cnt_q;
      tick_d   = 1'b0;
      done_d   = 1'b0;
`ifdef TICK_TIMER_SQUARE_EN
      square_d = square_q;
`endif

      if (stop) begin
         state_d  = ST_IDLE;
         pre_d    = '0;
         cnt_d    = '0;
`ifdef TICK_TIMER_SQUARE_EN
         square_d = 1'b0;
`endif
      end else if (div_load) begin
         // New period is measured from this edge; a tick due now is dropped.
         div_d = (div_value == '0) ? DIV_ONE : div_value;
         pre_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               pre_d = '0;
               cnt_d = '0;
               if (start) begin
                  state_d = ST_RUN;
                  mode_d  = mode;
               end
            end
            ST_RUN, ST_HOLD: begin
               // Resuming from HOLD counts on the resume edge, so a pause costs exactly its paused edges.
               if (!enable) begin
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_RUN;
                  if (pre_q == div_q - DIV_ONE) begin
                     pre_d  = '0;
                     tick_d = 1'b1;
`ifdef TICK_TIMER_SQUARE_EN
                     square_d = ~square_q;
`endif
                     if ((tc_value != '0) && (cnt_q == tc_value - CNT_ONE)) begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                        if (mode_q) begin
                           state_d = ST_IDLE;
`ifdef TICK_TIMER_SQUARE_EN
                           square_d = 1'b0;
`endif
                        end
                     end else begin
                        cnt_d = cnt_q + CNT_ONE;
                     end
                  end else begin
                     pre_d = pre_q + DIV_ONE;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               pre_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // NOTE: state is updated only with non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         mode_q   <= 1'b0;
         div_q    <= DIV_RESET;
         pre_q    <= '0;
         cnt_q    <= '0;
         tick_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef TICK_TIMER_SQUARE_EN
         square_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         div_q    <= div_d;
         pre_q    <= pre_d;
         cnt_q    <= cnt_d;
         tick_q   <= tick_d;
         done_q   <= done_d;
`ifdef TICK_TIMER_SQUARE_EN
         square_q <= square_d;
`endif
      end
   end

   assign tick       = tick_q;
   assign done       = done_q;
   assign tick_count = cnt_q;
   assign busy       = (state_q != ST_IDLE);
`ifdef TICK_TIMER_SQUARE_EN
   assign square     = square_q;
`endif

endmodule

// File: doc/tick_timer.md
# tick_timer

Parametrised tick generator and tick counter, the successor to the fixed 1,000,000-cycle slow-clock divider. It produces a one-cycle `tick` strobe every N clocks, with N loadable at run time, and counts ticks up to a programmable terminal count. It supports periodic and one-shot operation, pause and abort. It drives game pacing: blink rates, per-turn countdowns and display refresh.

## Interface
Parameters:
- `WIDTH`, 28: prescale counter and divisor width.
- `DEFAULT_DIV`, 1000000: divisor value after reset.
- `CNT_WIDTH`, 8: tick counter and terminal-count width.

Ports:
- `clock`, in, 1: single clock. All logic on the rising edge.
- `reset_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: level sampled each edge. Starts from IDLE; ignored otherwise.
- `stop`, in, 1: synchronous abort to IDLE.
- `enable`, in, 1: 0 pauses a running timer (RUN to HOLD).
- `mode`, in, 1: 0 = periodic, 1 = one-shot. Sampled only on the start edge.
- `div_load`, in, 1: latch `div_value` into the divisor register.
- `div_value`, in, WIDTH: new divisor. 0 is treated as 1.
- `tc_value`, in, CNT_WIDTH: terminal tick count. 0 means no terminal count.
- `tick`, out, 1: registered one-cycle strobe.
- `done`, out, 1: registered one-cycle strobe when the terminal count is reached.
- `tick_count`, out, CNT_WIDTH: ticks since start or last wrap.
- `busy`, out, 1: state is not IDLE.
- `square`, out, 1: only present with `TICK_TIMER_SQUARE_EN`.

## Operation
- Registers: `div_reg` (reset `DEFAULT_DIV`), prescaler `q`, `tick_count`, latched mode, state.
- States and transitions:
  - IDLE: `q` = 0 and `tick_count` = 0. `start` goes to RUN, latches `mode`, sets `q` = 0.
  - RUN: if `enable` = 0, go to HOLD; `q` and `tick_count` freeze and no tick is issued that edge. Otherwise `q` increments.
  - HOLD: if `enable` = 1, return to RUN and resume counting from the frozen `q`.
- Tick rule in RUN with `enable` = 1: when `q == div_reg-1`, set `q` to 0 and `tick` to 1. Otherwise `tick` is 0.
- Terminal count on a tick:
  - If `tc_value` ≠ 0 and `tick_count == tc_value-1`: `tick_count` goes to 0 and `done` to 1. In one-shot mode the state goes to IDLE on the same edge.
  - Otherwise `tick_count` increments. It wraps modulo 2^CNT_WIDTH when `tc_value` = 0.
- `div_load`, accepted in any state:
  - `div_reg` takes `div_value`, or 1 if `div_value` is 0.
  - `q` goes to 0. State and `tick_count` are unchanged.
  - The new period is measured from the load edge.
- Priority, highest first: `reset_n` low > `stop` > `div_load` > tick/terminal logic > `start`.
  - `stop` with `start` in the same cycle: stay in or go to IDLE.
  - `div_load` in a would-be tick cycle: no tick, no count.
- `stop` clears `q` and `tick_count`, goes to IDLE, and forces `tick`/`done` to 0 on the next cycle.
- `tc_value` is compared live. Lowering it below `tick_count` means no `done` until the counter wraps.

## Timing
- Reset values: `tick` = 0, `done` = 0, `tick_count` = 0, `busy` = 0, `square` = 0, state IDLE, `div_reg` = `DEFAULT_DIV`.
- `busy` is decoded from the state register. It is high the cycle after the start edge and low the cycle after the edge that enters IDLE.
- Start sampled at edge E0: the first `tick` is high in the cycle following edge E(div). Subsequent ticks follow every `div_reg` cycles while enabled.
- Divisor 1: `tick` is high every cycle from the cycle after E1.
- `done` coincides with its `tick` cycle. `tick_count` shows 0 in that same cycle.
- HOLD extends the period by exactly the number of paused edges.

## Configuration
- `TICK_TIMER_SQUARE_EN` defined:
  - `square` toggles on every tick edge, giving a 50% duty output at clock/(2·`div_reg`).
  - Cleared to 0 on reset and on every entry to IDLE.
- Not defined: the `square` port and its flop are absent.
- All other behaviour is identical in both builds.

## Test plan
- Reset, `DEFAULT_DIV` = 1000000, `start`, `enable` = 1: first tick is the cycle after edge 1000000, the next exactly 1000000 cycles later, `tick_count` = 1 then 2.
- `div_load` with `div_value` = 4, `tc_value` = 3, mode 0, start: ticks every 4 cycles, `done` on the 3rd tick with `tick_count` back to 0, pattern repeats, `busy` stays 1.
- Mode 1, div 2, `tc_value` = 2: `done` on the 2nd tick, `busy` low the next cycle, no further ticks until a new `start`.
- Div 5, drop `enable` for 3 cycles mid-period: that tick is delayed by exactly 3 cycles, `tick_count` unchanged during HOLD.
- `div_value` = 0 loaded, and separately `stop`+`start` together plus `div_load` on a would-be tick edge:
  - `div_value` = 0 gives a tick every cycle.
  - `stop`+`start` together keeps the block IDLE.
  - `div_load` on a would-be tick edge gives no tick, and the next tick comes `div` cycles after the load.
- With `TICK_TIMER_SQUARE_EN`, div 3: `square` period is 6 cycles, and it goes low on `stop`.
